// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   md_op_e      : decoded md op encoding carried in the ID/EX register
//   md_result_t  : 64-bit {hi, lo} result of a multiply or divide
//   default busy-cycle counts for MULT/MULTU and DIV/DIVU
package ex_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_result_t;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_multi_cycle(logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage md bus between the pipeline (master) and the mul/div unit (slave).
//   op_valid, op, cancel, a, b : issued op and forwarded operands
//   busy, md_busy              : in-flight flag and hazard-unit stall request
//   hi, lo                     : architectural HI/LO registers
interface ex_muldiv_unit_if;
    logic        op_valid;
    logic [2:0]  op;
    logic        cancel;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        md_busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output op_valid, op, cancel, a, b,
        input  busy, md_busy, hi, lo
    );

    modport slave (
        input  op_valid, op, cancel, a, b,
        output busy, md_busy, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_unit_md_result_calc.sv
// Combinational 64-bit multiply/divide datapath.
//   op_i  : md op (only MULT/MULTU/DIV/DIVU produce a result, others give 0)
//   a_i   : rs operand (multiplicand / dividend)
//   b_i   : rt operand (multiplier / divisor)
//   res_o : {hi, lo}; product, or {remainder, quotient} for divides
module md_result_calc
    import ex_muldiv_unit_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output md_result_t  res_o
);

    logic [63:0]        prod;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;

    always_comb begin
        res_o  = '0;
        prod   = '0;
        quot_s = '0;
        rem_s  = '0;
        case (op_i)
            MD_MULT: begin
                // Low 64 bits of the sign-extended product equal the signed product.
                prod  = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
                res_o = prod;
            end
            MD_MULTU: begin
                prod  = {32'd0, a_i} * {32'd0, b_i};
                res_o = prod;
            end
            MD_DIV: begin
                if (b_i == 32'd0) begin
                    res_o.lo = 32'hFFFF_FFFF;
                    res_o.hi = a_i;
                end else if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
                    // Quotient +2^31 does not fit; wraps to the dividend, remainder 0.
                    res_o.lo = 32'h8000_0000;
                    res_o.hi = 32'd0;
                end else begin
                    quot_s   = $signed(a_i) / $signed(b_i);
                    rem_s    = $signed(a_i) % $signed(b_i);
                    res_o.lo = quot_s;
                    res_o.hi = rem_s;
                end
            end
            MD_DIVU: begin
                if (b_i == 32'd0) begin
                    res_o.lo = 32'hFFFF_FFFF;
                    res_o.hi = a_i;
                end else begin
                    res_o.lo = a_i / b_i;
                    res_o.hi = a_i % b_i;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit with architectural HI/LO registers.
//   clk, reset : clock, synchronous active-high reset
//   md         : slave side of the md bus (op in, busy/md_busy/hi/lo out)
// A MULT/DIV result is computed at issue and parked in a pending register;
// a down-counter models the multi-cycle latency before it lands in HI/LO.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input logic              clk,
    input logic              reset,
    ex_muldiv_unit_if.slave  md
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    md_result_t      pend_q, pend_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    md_result_t      calc_res;
    logic            accept;

    md_result_calc u_calc (
        .op_i  (md.op),
        .a_i   (md.a),
        .b_i   (md.b),
        .res_o (calc_res)
    );

    // Ops seen while busy are dropped; the hazard unit is expected to stall them.
    assign accept = md.op_valid & ~md.cancel & ~busy_q;

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        pend_d = pend_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (busy_q) begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
                hi_d   = pend_q.hi;
                lo_d   = pend_q.lo;
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end else if (accept) begin
            case (md.op)
                MD_MULT, MD_MULTU: begin
                    pend_d = calc_res;
                    cnt_d  = CntW'(MULT_CYCLES);
                    busy_d = 1'b1;
                end
                MD_DIV, MD_DIVU: begin
                    pend_d = calc_res;
                    cnt_d  = CntW'(DIV_CYCLES);
                    busy_d = 1'b1;
                end
                MD_MTHI: hi_d = md.a;
                MD_MTLO: lo_d = md.a;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            pend_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            pend_q <= pend_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign md.busy    = busy_q;
    assign md.md_busy = busy_q | (md.op_valid & is_multi_cycle(md.op) & ~md.cancel);
    assign md.hi      = hi_q;
    assign md.lo      = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed cases plus random ops checked
// against a plain-arithmetic reference model of HI/LO and busy timing.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ex_muldiv_unit_if md_if ();

    ex_muldiv_unit #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if)
    );

    typedef struct {
        int          due;
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference state: m* = HI/LO once everything accepted has committed,
    // o* = HI/LO visible while the current op is still in flight.
    logic [31:0] mhi = 0, mlo = 0, ohi = 0, olo = 0;
    int          busy_end = 0;
    int          viol_exp = 0;
    int          viol_seen = 0;

    always @(posedge clk) cyc++;

    // Protocol watch: an op issued into a busy unit.
    always @(posedge clk)
        if (!reset && md_if.op_valid && !md_if.cancel && md_if.busy &&
            md_if.op >= 3'd1 && md_if.op <= 3'd6)
            viol_seen++;

    // Monitor: compare every expectation due after the current edge.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due == cyc) begin
                checks++;
                if (md_if.busy !== sb_q[i].busy || md_if.hi !== sb_q[i].hi ||
                    md_if.lo !== sb_q[i].lo) begin
                    errors++;
                    $display("FAIL %s @%0d: got busy=%0b hi=%h lo=%h, want busy=%0b hi=%h lo=%h",
                             sb_q[i].name, cyc, md_if.busy, md_if.hi, md_if.lo,
                             sb_q[i].busy, sb_q[i].hi, sb_q[i].lo);
                end
                sb_q.delete(i);
            end
        end
    end

    function automatic md_result_t ref_model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        md_result_t      r;
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        if (op == 3'd1) begin
            sp = sa * sb;
            r  = sp;
        end else if (op == 3'd2) begin
            up = ua * ub;
            r  = up;
        end else if (b == 32'd0) begin
            r.hi = a;
            r.lo = 32'hFFFF_FFFF;
        end else if (op == 3'd3) begin
            // 64-bit division never overflows; the low 32 bits give the wrapped quotient.
            sq   = sa / sb;
            sr   = sa % sb;
            r.lo = 32'(sq);
            r.hi = 32'(sr);
        end else begin
            r.lo = 32'(ua / ub);
            r.hi = 32'(ua % ub);
        end
        return r;
    endfunction

    task automatic push(input int due, input logic busy, input logic [31:0] hi,
                        input logic [31:0] lo, input string name);
        exp_t e;
        e.due = due; e.busy = busy; e.hi = hi; e.lo = lo; e.name = name;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of stimulus; the op is sampled at the following rising edge.
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic c, input string name);
        int         now, n;
        logic       mb, md_exp, acc;
        md_result_t r;
        @(negedge clk);
        #1;
        md_if.op_valid = v;
        md_if.op       = op;
        md_if.a        = a;
        md_if.b        = b;
        md_if.cancel   = c;
        now = cyc;
        mb  = now < busy_end;
        md_exp = mb || (v && !c && op >= 3'd1 && op <= 3'd4);
        #1;
        checks++;
        if (md_if.md_busy !== md_exp) begin
            errors++;
            $display("FAIL %s md_busy @%0d: got %0b want %0b", name, now, md_if.md_busy, md_exp);
        end
        acc = v && !c && !mb;
        if (v && !c && mb && op >= 3'd1 && op <= 3'd6) viol_exp++;
        if (acc && op >= 3'd1 && op <= 3'd4) begin
            r   = ref_model(op, a, b);
            ohi = mhi; olo = mlo;
            mhi = r.hi; mlo = r.lo;
            n   = (op <= 3'd2) ? MC : DC;
            busy_end = now + 1 + n;
            push(now + 1, 1'b1, ohi, olo, {name, "_start"});
            if (n > 1) push(now + n, 1'b1, ohi, olo, {name, "_last_busy"});
            push(now + 1 + n, 1'b0, mhi, mlo, name);
        end else if (acc && op == 3'd5) begin
            mhi = a;
            push(now + 1, 1'b0, mhi, mlo, name);
        end else if (acc && op == 3'd6) begin
            mlo = a;
            push(now + 1, 1'b0, mhi, mlo, name);
        end else if (now + 1 < busy_end) begin
            push(now + 1, 1'b1, ohi, olo, name);
        end else begin
            push(now + 1, 1'b0, mhi, mlo, name);
        end
    endtask

    task automatic idle(input string name);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, name);
    endtask

    task automatic idle_free(input string name);
        while (cyc < busy_end) idle(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset          = 1'b1;
        md_if.op_valid = 1'b0;
        md_if.op       = 3'd0;
        md_if.cancel   = 1'b0;
        md_if.a        = '0;
        md_if.b        = '0;
        sb_q.delete();
        busy_end = 0;
        mhi = 0; mlo = 0; ohi = 0; olo = 0;
        push(cyc + 1, 1'b0, 32'd0, 32'd0, "reset");
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        v, c;
        logic [2:0]  op;
        logic [31:0] a, b;
        md_if.op_valid = 1'b0;
        md_if.op       = 3'd0;
        md_if.cancel   = 1'b0;
        md_if.a        = '0;
        md_if.b        = '0;
        do_reset();

        step(1'b1, MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, "mult_neg");   idle_free("w");
        step(1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu");     idle_free("w");
        step(1'b1, MD_DIV, -32'sd7, 32'd2, 1'b0, "div_neg");           idle_free("w");
        step(1'b1, MD_DIVU, 32'd7, 32'd2, 1'b0, "divu");               idle_free("w");
        step(1'b1, MD_DIV, 32'd5, 32'd0, 1'b0, "div_zero");            idle_free("w");
        step(1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf"); idle_free("w");

        step(1'b1, MD_MULT, 32'd7, 32'd9, 1'b1, "mult_cancelled");
        idle("after_cancel");
        step(1'b1, MD_MULT, 32'd123, 32'd456, 1'b0, "mult_cancel_busy");
        idle("b1");
        idle("b2");
        step(1'b0, MD_NONE, 32'd0, 32'd0, 1'b1, "cancel_in_busy");
        idle_free("w");

        step(1'b1, MD_MTHI, 32'h0000_1234, 32'd0, 1'b0, "mthi");
        step(1'b1, MD_DIV, 32'd9, 32'd4, 1'b0, "div_9_4");
        step(1'b1, MD_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0, "mtlo_while_busy");
        idle_free("w");

        step(1'b1, MD_DIV, 32'd100, 32'd7, 1'b0, "div_then_reset");
        idle("b1");
        do_reset();
        step(1'b1, MD_MULT, 32'd3, 32'd4, 1'b0, "mult_3x4");
        idle_free("w");

        for (int i = 0; i < 300; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            a  = rand_operand();
            b  = rand_operand();
            c  = ($urandom_range(0, 7) == 0);
            // Mostly behave like a stalled pipeline while busy; occasionally violate.
            if (cyc < busy_end && $urandom_range(0, 7) != 0) v = 1'b0;
            step(v, op, a, b, c, "rand");
        end
        idle_free("w");
        idle("drain1");
        idle("drain2");
        @(negedge clk);
        #1;

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
        end
        checks++;
        if (viol_seen != viol_exp) begin
            errors++;
            $display("FAIL protocol_violations: got %0d want %0d", viol_seen, viol_exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
